// File: rtl/mux21_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux21_pop_arbiter
// Brief    : Pop/select sequencer for the 2:1 10-bit mux stage. Arbitrates
//            the shared mux output between two source FIFOs using
//            round-robin bursts of up to BURST_LEN pops. Pops are one-hot
//            and never target an empty source or an almost-full destination.
// Options  : define ARB_STRICT_PRIO_EN to give channel 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
module mux21_pop_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int BCNT_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_en,
    input  logic              fifo0_empty,
    input  logic              fifo1_empty,
    input  logic              dest_afull,
    output logic              pop0,
    output logic              pop1,
    output logic [1:0]        grant,
    output logic [BCNT_W-1:0] burst_cnt,
    output logic              arb_idle
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_gnt0 = 2'd1;
    localparam logic [1:0] c_st_gnt1 = 2'd2;

    localparam logic [BCNT_W-1:0] c_burst_last = BCNT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] c_burst_one  = BCNT_W'(1);

    logic [1:0]        r_state;
    logic [BCNT_W-1:0] r_burst_cnt;
    logic              r_rr_last;   // channel that most recently finished a grant

    logic [1:0]        w_state_nxt;
    logic [BCNT_W-1:0] w_burst_nxt;
    logic              w_rr_nxt;
    logic              w_ne0;
    logic              w_ne1;
    logic              w_can_pop;
    logic              w_own_ne;
    logic              w_oth_ne;
    logic              w_own_id;
    logic [1:0]        w_oth_st;

    assign w_ne0     = ~fifo0_empty;
    assign w_ne1     = ~fifo1_empty;
    // Reset gates the pops directly so they drop in the cycle reset is seen.
    assign w_can_pop = arb_en & ~dest_afull & ~reset;

    assign pop0      = (r_state == c_st_gnt0) & w_can_pop & w_ne0;
    assign pop1      = (r_state == c_st_gnt1) & w_can_pop & w_ne1;
    assign grant     = {r_state == c_st_gnt1, r_state == c_st_gnt0};
    assign burst_cnt = r_burst_cnt;
    assign arb_idle  = (r_state == c_st_idle);

    // State, burst counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_burst_cnt <= '0;
            r_rr_last   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rr_last   <= w_rr_nxt;
        end
    end

    // Next-state logic, written once from the point of view of the current owner.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_rr_nxt    = r_rr_last;
        w_own_id    = (r_state == c_st_gnt1);
        w_own_ne    = w_own_id ? w_ne1 : w_ne0;
        w_oth_ne    = w_own_id ? w_ne0 : w_ne1;
        w_oth_st    = w_own_id ? c_st_gnt0 : c_st_gnt1;

        if (!arb_en || r_state == 2'd3) begin
            // Disabled (or unreachable encoding): park in IDLE, keep the RR pointer.
            w_state_nxt = c_st_idle;
            w_burst_nxt = '0;
        end else if (r_state == c_st_idle) begin
`ifdef ARB_STRICT_PRIO_EN
            if (w_ne0)
                w_state_nxt = c_st_gnt0;
            else if (w_ne1)
                w_state_nxt = c_st_gnt1;
`else
            if (w_ne0 && w_ne1)
                w_state_nxt = r_rr_last ? c_st_gnt0 : c_st_gnt1;
            else if (w_ne0)
                w_state_nxt = c_st_gnt0;
            else if (w_ne1)
                w_state_nxt = c_st_gnt1;
`endif
`ifdef ARB_STRICT_PRIO_EN
        end else if (r_state == c_st_gnt1 && w_ne0) begin
            // Channel 0 pre-empts channel 1 after any cycle it has data.
            w_state_nxt = c_st_gnt0;
            w_burst_nxt = '0;
            w_rr_nxt    = 1'b1;
`endif
        end else if (!w_own_ne) begin
            // Owner ran dry: hand over or go idle.
            w_burst_nxt = '0;
            w_rr_nxt    = w_own_id;
            w_state_nxt = w_oth_ne ? w_oth_st : c_st_idle;
        end else if (dest_afull) begin
            // Backpressure: hold everything, no pop this cycle.
            w_state_nxt = r_state;
        end else if (r_burst_cnt == c_burst_last) begin
            // Last pop of the burst; own FIFO is non-empty so staying is the fallback.
            w_burst_nxt = '0;
            w_rr_nxt    = w_own_id;
`ifndef ARB_STRICT_PRIO_EN
            if (w_oth_ne)
                w_state_nxt = w_oth_st;
`endif
        end else begin
            w_burst_nxt = r_burst_cnt + c_burst_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux21_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux21_pop_arbiter
// Brief    : Self-checking bench for mux21_pop_arbiter. Source FIFOs are
//            modelled as word counts; a cycle-level reference model tracks
//            owner / burst count / last-served channel as plain integers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux21_pop_arbiter;

    localparam int BL = 4;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          arb_en;
    logic          fifo0_empty;
    logic          fifo1_empty;
    logic          dest_afull;
    logic          pop0;
    logic          pop1;
    logic [1:0]    grant;
    logic [BW-1:0] burst_cnt;
    logic          arb_idle;

    int n_cmp = 0;
    int n_err = 0;
    int words[2];            // occupancy of the two source FIFOs
    int m_own  = -1;         // model owner: -1 idle, 0 or 1
    int m_cnt  = 0;          // model pops done in the current grant
    int m_last = 1;          // model last-served channel

    always #5 clk = ~clk;

    mux21_pop_arbiter #(.BURST_LEN(BL), .BCNT_W(BW)) dut (
        .clk        (clk),
        .reset      (reset),
        .arb_en     (arb_en),
        .fifo0_empty(fifo0_empty),
        .fifo1_empty(fifo1_empty),
        .dest_afull (dest_afull),
        .pop0       (pop0),
        .pop1       (pop1),
        .grant      (grant),
        .burst_cnt  (burst_cnt),
        .arb_idle   (arb_idle)
    );

    // One clock: drive empties from occupancy, compare mid-cycle, advance model.
    task automatic step(input string tag, output logic op0, output logic op1);
        logic [7:0] exp_v;
        logic [7:0] got_v;
        logic [1:0] eg;
        logic       e0;
        logic       e1;
        int         ne[2];
        int         x;
        int         o;
        fifo0_empty = (words[0] == 0);
        fifo1_empty = (words[1] == 0);
        @(negedge clk);
        e0 = (m_own == 0) && arb_en && !fifo0_empty && !dest_afull && !reset;
        e1 = (m_own == 1) && arb_en && !fifo1_empty && !dest_afull && !reset;
        eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
        exp_v = {e0, e1, eg, BW'(m_cnt), (m_own < 0)};
        got_v = {pop0, pop1, grant, burst_cnt, arb_idle};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t: got {pop0,pop1,grant,burst,idle}=%b want %b",
                     tag, $time, got_v, exp_v);
        end
        n_cmp++;
        if (pop0 === 1'b1 && pop1 === 1'b1) begin
            n_err++;
            $display("FAIL %s_onehot t=%0t: got pop0=%b pop1=%b want at most one", tag, $time, pop0, pop1);
        end
        op0 = pop0;
        op1 = pop1;
        // Reference arbitration rules.
        ne[0] = (words[0] > 0) ? 1 : 0;
        ne[1] = (words[1] > 0) ? 1 : 0;
        if (reset) begin
            m_own = -1; m_cnt = 0; m_last = 1;
        end else if (!arb_en) begin
            m_own = -1; m_cnt = 0;
        end else if (m_own < 0) begin
`ifdef ARB_STRICT_PRIO_EN
            if (ne[0] != 0) m_own = 0;
            else if (ne[1] != 0) m_own = 1;
`else
            if (ne[0] != 0 && ne[1] != 0) m_own = 1 - m_last;
            else if (ne[0] != 0) m_own = 0;
            else if (ne[1] != 0) m_own = 1;
`endif
        end else begin
            x = m_own;
            o = 1 - x;
`ifdef ARB_STRICT_PRIO_EN
            if (x == 1 && ne[0] != 0) begin
                m_own = 0; m_cnt = 0; m_last = 1;
            end else
`endif
            if (ne[x] == 0) begin
                m_cnt = 0; m_last = x; m_own = (ne[o] != 0) ? o : -1;
            end else if (dest_afull) begin
                m_cnt = m_cnt;
            end else if (m_cnt == BL - 1) begin
                m_cnt = 0; m_last = x;
`ifndef ARB_STRICT_PRIO_EN
                if (ne[o] != 0) m_own = o;
`endif
            end else begin
                m_cnt++;
            end
        end
        if (e0) words[0]--;
        if (e1) words[1]--;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic p0, p1;
        reset = 1'b1; arb_en = 1'b1; dest_afull = 1'b0;
        words[0] = 10; words[1] = 10;
        fifo0_empty = 1'b0; fifo1_empty = 1'b0;
        @(posedge clk);
        #1;
        step("reset_c1", p0, p1);
        step("reset_c2", p0, p1);
        n_cmp++;
        if (arb_idle !== 1'b1 || grant !== 2'b00 || burst_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_state: got idle=%b grant=%b burst=%0d want 1/00/0", arb_idle, grant, burst_cnt);
        end
        reset = 1'b0;
    endtask

`ifndef ARB_STRICT_PRIO_EN
    task automatic test_fairness();
        logic p0, p1;
        int   seq[$];
        int   exp_seq[20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
        int   bad;
        arb_en = 1'b0; words[0] = 10; words[1] = 10;
        step("fair_off", p0, p1);
        arb_en = 1'b1;
        step("fair_rise", p0, p1);
        n_cmp++;
        if (p0 !== 1'b0 || p1 !== 1'b0) begin
            n_err++;
            $display("FAIL fair_latency: got pop0=%b pop1=%b in enable cycle want 0 0", p0, p1);
        end
        for (int i = 0; i < 30; i++) begin
            step("fair", p0, p1);
            if (p0 === 1'b1) seq.push_back(0);
            if (p1 === 1'b1) seq.push_back(1);
        end
        bad = (seq.size() != 20) ? 1 : 0;
        for (int i = 0; i < 20 && i < seq.size(); i++)
            if (seq[i] != exp_seq[i]) bad = 1;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL fair_sequence: got %0d pops %p want 20 pops %p", seq.size(), seq, exp_seq);
        end
    endtask

    task automatic test_backpressure();
        logic p0, p1;
        int   own;
        int   n_own;
        int   guard;
        words[0] = 10; words[1] = 10; arb_en = 1'b1; dest_afull = 1'b0;
        guard = 0;
        while (!(m_own >= 0 && m_cnt == 2) && guard < 20) begin
            step("bp_pre", p0, p1);
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_err++;
            $display("FAIL bp_reach: got no burst_cnt=2 within 20 cycles want reached");
        end
        own = m_own;
        dest_afull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("bp_hold", p0, p1);
            n_cmp++;
            if (p0 !== 1'b0 || p1 !== 1'b0 || burst_cnt !== 3'd2) begin
                n_err++;
                $display("FAIL bp_hold: got pop0=%b pop1=%b burst=%0d want 0 0 2", p0, p1, burst_cnt);
            end
        end
        dest_afull = 1'b0;
        n_own = 0;
        guard = 0;
        p0 = 1'b0; p1 = 1'b0;
        while (guard < 10) begin
            step("bp_resume", p0, p1);
            guard++;
            if ((own == 0 && p1 === 1'b1) || (own == 1 && p0 === 1'b1)) break;
            if ((own == 0 && p0 === 1'b1) || (own == 1 && p1 === 1'b1)) n_own++;
        end
        n_cmp++;
        if (n_own != 2 || guard >= 10) begin
            n_err++;
            $display("FAIL bp_yield: got %0d more pops before yield (cycles=%0d) want 2", n_own, guard);
        end
    endtask

    task automatic test_drain();
        logic p0, p1;
        int   n0;
        arb_en = 1'b0; words[0] = 2; words[1] = 0;
        step("drain_off", p0, p1);
        arb_en = 1'b1;
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            step("drain", p0, p1);
            if (p0 === 1'b1) n0++;
        end
        n_cmp++;
        if (n0 != 2 || arb_idle !== 1'b1) begin
            n_err++;
            $display("FAIL drain_idle: got pops=%0d idle=%b want 2 1", n0, arb_idle);
        end
        words[1] = 5;
        step("drain_wake", p0, p1);
        n_cmp++;
        if (grant !== 2'b10) begin
            n_err++;
            $display("FAIL drain_wake_grant: got %b want 10", grant);
        end
    endtask

    task automatic test_en_drop();
        logic       p0, p1;
        logic [1:0] eg;
        int         guard;
        words[0] = 10; words[1] = 10; arb_en = 1'b1;
        guard = 0;
        while (!(m_own >= 0 && m_cnt == 1) && guard < 20) begin
            step("en_pre", p0, p1);
            guard++;
        end
        arb_en = 1'b0;
        step("en_drop", p0, p1);
        n_cmp++;
        if (p0 !== 1'b0 || p1 !== 1'b0 || arb_idle !== 1'b1 || guard >= 20) begin
            n_err++;
            $display("FAIL en_drop: got pop0=%b pop1=%b idle=%b want 0 0 1", p0, p1, arb_idle);
        end
        // Tie goes to the channel that did not finish the last grant.
        eg = (m_last == 1) ? 2'b01 : 2'b10;
        arb_en = 1'b1;
        step("en_back", p0, p1);
        n_cmp++;
        if (grant !== eg) begin
            n_err++;
            $display("FAIL en_tie: got grant=%b want %b", grant, eg);
        end
    endtask
`else
    task automatic test_strict_prio();
        logic p0, p1;
        int   n1;
        int   run0;
        arb_en = 1'b1; dest_afull = 1'b0; words[0] = 0; words[1] = 10;
        for (int i = 0; i < 3; i++) step("sp_pre", p0, p1);
        words[0] = 12;
        n1 = 0;
        run0 = 0;
        for (int i = 0; i < 10; i++) begin
            step("sp_run", p0, p1);
            if (p1 === 1'b1 && run0 == 0) n1++;
            if (p0 === 1'b1) run0++;
        end
        n_cmp++;
        if (n1 > 1 || run0 < BL + 2) begin
            n_err++;
            $display("FAIL strict_prio: got extra pop1=%0d pop0 run=%0d want <=1 and >=%0d", n1, run0, BL + 2);
        end
    endtask
`endif

    task automatic test_random();
        logic p0, p1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 3) == 0 && words[c] < 20) words[c] += $urandom_range(1, 3);
            dest_afull = ($urandom_range(0, 3) == 0);
            arb_en     = ($urandom_range(0, 9) != 0);
            reset      = ($urandom_range(0, 99) == 0);
            step("random", p0, p1);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
`ifndef ARB_STRICT_PRIO_EN
        test_fairness();
        test_backpressure();
        test_drain();
        test_en_drop();
`else
        test_strict_prio();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
